// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data/fetch arbiter for a shared single-port synchronous-read memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]    starve_q, starve_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
    logic             d_rd_q, d_rd_d;
    logic             i_rd_q, i_rd_d;
    logic             starved;

    assign starved = (starve_q == STARVE_LIM);

    // Fetch wins when alone or once it has been denied STARVE_MAX times in a row.
    always_comb begin
        i_gnt = !rst && i_req && (!d_req || starved);
        d_gnt = !rst && d_req && !(i_req && (!d_req || starved));
    end

    always_comb begin
        mem_en    = d_gnt | i_gnt;
        mem_we    = d_gnt ? d_we : 4'b0000;
        mem_addr  = i_gnt ? i_addr : d_addr;
        mem_wdata = d_gnt ? d_wdata : 32'h0;
    end

    always_comb begin
        starve_d = starve_q;
        if (i_gnt || !i_req) begin
            starve_d = '0;
        end else if (d_gnt && !starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (d_req && i_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        d_rd_d = d_gnt && (d_we == 4'b0000);
        i_rd_d = i_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q       <= '0;
            conflict_cnt_q <= '0;
            d_rd_q         <= 1'b0;
            i_rd_q         <= 1'b0;
        end else begin
            starve_q       <= starve_d;
            conflict_cnt_q <= conflict_cnt_d;
            d_rd_q         <= d_rd_d;
            i_rd_q         <= i_rd_d;
        end
    end

    // Both ports see the raw memory output; rvalid says whose read it was.
    assign d_rvalid     = d_rd_q;
    assign i_rvalid     = i_rd_q;
    assign d_rdata      = mem_rdata;
    assign i_rdata      = mem_rdata;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, i_req;
    logic [3:0]  d_we;
    logic [11:0] d_addr, i_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, i_gnt, i_rvalid;
    logic [31:0] d_rdata, i_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    logic        u2_d_gnt, u2_d_rvalid, u2_i_gnt, u2_i_rvalid, u2_mem_en;
    logic [31:0] u2_d_rdata, u2_i_rdata, u2_mem_wdata;
    logic [3:0]  u2_mem_we;
    logic [11:0] u2_mem_addr;
    logic [3:0]  cnt4;

    logic [31:0] mem [0:4095];
    logic        mem_loaded = 1'b0;
    logic [31:0] ref_mem [0:4095];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(u2_d_gnt), .d_rvalid(u2_d_rvalid), .d_rdata(u2_d_rdata),
        .i_req(i_req), .i_addr(i_addr),
        .i_gnt(u2_i_gnt), .i_rvalid(u2_i_rvalid), .i_rdata(u2_i_rdata),
        .mem_en(u2_mem_en), .mem_we(u2_mem_we), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(cnt4)
    );

    // Memory instance: synchronous read, byte-enabled write, preloaded on the first edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < 4096; a++) mem[a] <= (a < 64) ? 32'h13 + 32'(a) : 32'h0;
            mem_loaded <= 1'b1;
            mem_rdata  <= 32'h0;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: arbitration rules, latency-1 read return and counters from first principles.
    int          m_starve, m_cnt, m_cnt4;
    logic        m_d_pend, m_i_pend;
    logic [31:0] m_pend_data;
    logic        e_d, e_i;

    initial begin
        for (int a = 0; a < 4096; a++) ref_mem[a] = (a < 64) ? 32'h13 + 32'(a) : 32'h0;
        m_starve = 0; m_cnt = 0; m_cnt4 = 0;
        m_d_pend = 1'b0; m_i_pend = 1'b0; m_pend_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("m_rst_dgnt", 32'(d_gnt), 32'h0);
                check("m_rst_ignt", 32'(i_gnt), 32'h0);
                check("m_rst_mem_en", 32'(mem_en), 32'h0);
                check("m_rst_rvalid", {30'h0, d_rvalid, i_rvalid}, 32'h0);
                check("m_rst_cnt", 32'(conflict_cnt), 32'h0);
                m_starve = 0; m_cnt = 0; m_cnt4 = 0;
                m_d_pend = 1'b0; m_i_pend = 1'b0;
            end else begin
                e_i = i_req && (!d_req || m_starve >= 4);
                e_d = d_req && !e_i;
                check("m_dgnt", 32'(d_gnt), 32'(e_d));
                check("m_ignt", 32'(i_gnt), 32'(e_i));
                check("m_mem_en", 32'(mem_en), 32'(e_d || e_i));
                check("m_mem_we", 32'(mem_we), e_d ? 32'(d_we) : 32'h0);
                if (e_i) check("m_mem_addr_i", 32'(mem_addr), 32'(i_addr));
                if (e_d) check("m_mem_addr_d", 32'(mem_addr), 32'(d_addr));
                if (e_d && d_we != 4'b0000) check("m_mem_wdata", mem_wdata, d_wdata);
                check("m_d_rvalid", 32'(d_rvalid), 32'(m_d_pend));
                check("m_i_rvalid", 32'(i_rvalid), 32'(m_i_pend));
                if (m_d_pend) check("m_d_rdata", d_rdata, m_pend_data);
                if (m_i_pend) check("m_i_rdata", i_rdata, m_pend_data);
                check("m_conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
                check("m_cnt4", 32'(cnt4), 32'(m_cnt4));

                if (d_req && i_req) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
                if (e_i || !i_req) m_starve = 0;
                else if (e_d && m_starve < 4) m_starve++;
                m_d_pend = e_d && (d_we == 4'b0000);
                m_i_pend = e_i;
                if (e_i) m_pend_data = ref_mem[i_addr];
                if (e_d) begin
                    if (d_we == 4'b0000) m_pend_data = ref_mem[d_addr];
                    else for (int b = 0; b < 4; b++)
                        if (d_we[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dr, input logic [3:0] we, input logic [11:0] da,
                         input logic [31:0] dw, input logic ir, input logic [11:0] ia);
        d_req = dr; d_we = we; d_addr = da; d_wdata = dw; i_req = ir; i_addr = ia;
        #1;
    endtask

    logic [31:0] fetch_exp [0:3];

    initial begin
        fetch_exp[0] = 32'h13; fetch_exp[1] = 32'h14; fetch_exp[2] = 32'h15; fetch_exp[3] = 32'h16;
        rst = 1'b1;
        drive(1'b1, 4'h0, 12'h0, 32'h0, 1'b1, 12'h0);
        tick;
        check("reset_dgnt", 32'(d_gnt), 32'h0);
        check("reset_ignt", 32'(i_gnt), 32'h0);
        check("reset_mem_en", 32'(mem_en), 32'h0);
        check("reset_cnt", 32'(conflict_cnt), 32'h0);
        drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
        tick;
        rst = 1'b0;

        // Fetch only
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'(k));
            check("t1_ignt", 32'(i_gnt), 32'h1);
            tick;
            check("t1_irvalid", 32'(i_rvalid), 32'h1);
            check("t1_irdata", i_rdata, fetch_exp[k]);
        end
        drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
        tick;

        // Store then load
        drive(1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 1'b0, 12'h0);
        check("t2_st_dgnt", 32'(d_gnt), 32'h1);
        tick;
        check("t2_st_norvalid", 32'(d_rvalid), 32'h0);
        drive(1'b1, 4'h0, 12'h010, 32'h0, 1'b0, 12'h0);
        tick;
        check("t2_ld_rvalid", 32'(d_rvalid), 32'h1);
        check("t2_ld_rdata", d_rdata, 32'hDEADBEEF);

        // Byte write
        drive(1'b1, 4'hF, 12'h020, 32'h11223344, 1'b0, 12'h0);
        tick;
        drive(1'b1, 4'b0010, 12'h020, 32'h0000AA00, 1'b0, 12'h0);
        tick;
        drive(1'b1, 4'h0, 12'h020, 32'h0, 1'b0, 12'h0);
        tick;
        check("t4_rvalid", 32'(d_rvalid), 32'h1);
        check("t4_rdata", d_rdata, 32'h1122AA44);
        drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
        tick;

        // Starvation and counter saturation
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            drive(1'b1, 4'h0, 12'h030, 32'h0, 1'b1, 12'h005);
            check("t3_dgnt", 32'(d_gnt), (c % 5 == 0) ? 32'h0 : 32'h1);
            check("t3_ignt", 32'(i_gnt), (c % 5 == 0) ? 32'h1 : 32'h0);
            tick;
            if (c == 10) check("t3_cnt10", 32'(conflict_cnt), 32'd10);
        end
        check("t6_cnt4_sat", 32'(cnt4), 32'd15);
        check("t6_cnt16", 32'(conflict_cnt), 32'd20);

        // Reset mid-read
        drive(1'b0, 4'h0, 12'h030, 32'h0, 1'b1, 12'h007);
        check("t5_ignt", 32'(i_gnt), 32'h1);
        tick;
        check("t5_irvalid_pre", 32'(i_rvalid), 32'h1);
        rst = 1'b1;
        drive(1'b1, 4'h0, 12'h030, 32'h0, 1'b1, 12'h007);
        check("t5_irvalid_clr", 32'(i_rvalid), 32'h0);
        check("t5_gnts", {30'h0, d_gnt, i_gnt}, 32'h0);
        check("t5_mem_en", 32'(mem_en), 32'h0);
        check("t5_cnt", 32'(conflict_cnt), 32'h0);
        check("t5_cnt4", 32'(cnt4), 32'h0);
        tick;
        check("t5_rvalid_hold", {30'h0, d_rvalid, i_rvalid}, 32'h0);
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 4'h0, 12'h030, 32'h0, 1'b1, 12'h007);
            check("t5_post_ignt", 32'(i_gnt), (c == 5) ? 32'h1 : 32'h0);
            tick;
        end
        check("t5_post_cnt", 32'(conflict_cnt), 32'd5);
        drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, synchronous-read BIOS/program memory between two requesters: the data port (load/store stage) and the instruction-fetch port.
- The data port has fixed priority. A starvation counter guarantees fetch forward progress.
- Sits between the CPU pipeline and the memory instance. Read data returns one cycle after grant.
- Also exposes a saturating conflict counter for performance debug.

Parameters:
- ADDR_W, 12, word-address width (4096 x 32-bit words).
- STARVE_MAX, 4, consecutive fetch-denied cycles after which fetch wins the next conflict.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- d_req  in  1  data-port request.
- d_we  in  4  byte write enables; 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (read only).
- d_rdata  out  32  read data to data port.
- i_req  in  1  fetch request (always a read).
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  32  instruction word.
- mem_en  out  1  memory enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid one cycle after mem_en with mem_we==0.
- conflict_cnt  out  CNT_W  number of cycles with d_req and i_req both high; saturates.

Behaviour:
Reset values:
- d_gnt, i_gnt, d_rvalid, i_rvalid = 0.
- mem_en = 0, mem_we = 0.
- Starvation counter (starve) = 0, conflict_cnt = 0, rvalid pipeline regs = 0.
- While rst is high, grants and mem_en are forced 0 combinationally.

Grant (combinational, same cycle as request):
- Only d_req: d_gnt = 1.
- Only i_req: i_gnt = 1.
- Both high and starve < STARVE_MAX: d_gnt = 1, i_gnt = 0.
- Both high and starve == STARVE_MAX: i_gnt = 1, d_gnt = 0.
- Neither high: no grant, mem_en = 0.
- d_gnt and i_gnt are never high together.

Memory drive:
- mem_en = d_gnt | i_gnt.
- mem_addr and mem_wdata come from the winner.
- mem_we = d_we when d wins, 0 when i wins.

Requester contract:
- Hold req, addr, we and wdata stable until gnt is seen.
- A new request may be presented in the cycle right after gnt, so back-to-back grants are allowed.

Starvation counter:
- Increments (saturating at STARVE_MAX) when i_req && d_gnt.
- Clears to 0 when i_gnt or when !i_req.

Read return (latency 1):
- Registered flags d_rd_q = d_gnt && (d_we == 0) and i_rd_q = i_gnt.
- d_rvalid = d_rd_q; i_rvalid = i_rd_q.
- d_rdata = i_rdata = mem_rdata (unregistered pass-through). rvalid qualifies which port owns the data.
- Writes never produce rvalid.
- A fetch grant after a data-read grant in consecutive cycles gives d_rvalid then i_rvalid on consecutive cycles.

conflict_cnt:
- Increments on every cycle with d_req && i_req.
- Holds at 2^CNT_W-1.

Reset mid-operation:
- If rst asserts in the cycle after a read grant, rvalid is cleared immediately and no data is delivered.
- No request survives reset; requesters must reissue.

Test Plan:
1. Fetch only:
   - Stimulus: i_req=1, i_addr=0x000..0x003 over 4 cycles, memory preloaded with 0x00000013 + addr.
   - Required: i_gnt high each cycle; i_rvalid high cycles 2-5; i_rdata = 0x13, 0x14, 0x15, 0x16.
2. Store then load:
   - Stimulus: d_req with d_we=4'b1111, d_addr=0x010, d_wdata=0xDEADBEEF; next cycle d_we=0 at the same address.
   - Required: no d_rvalid for the store; d_rvalid one cycle after the load grant with d_rdata=0xDEADBEEF.
3. Starvation, STARVE_MAX=4:
   - Stimulus: d_req and i_req held high continuously.
   - Required: d_gnt in cycles 1-4, i_gnt in cycle 5, starve reset to 0, then d_gnt in cycles 6-9 and i_gnt in cycle 10.
   - Required: conflict_cnt = 10 after 10 cycles.
4. Byte write:
   - Stimulus: word 0x020 = 0x11223344, then d_we=4'b0010 with d_wdata=0x0000AA00, then read.
   - Required: d_rdata = 0x1122AA44.
5. Reset mid-read:
   - Stimulus: i_gnt in cycle N, rst asserted asynchronously between posedge N and posedge N+1.
   - Required: i_rvalid=0 immediately; all grants and mem_en 0 while rst is high; starve=0 and conflict_cnt=0.
6. Counter saturation:
   - Stimulus: CNT_W=4, 20 conflict cycles.
   - Required: conflict_cnt holds at 15.
